// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit-index width,
// blank patterns and the active-low hex glyph table (bit order g..a).
package seg_pkg;

  localparam int NUM_W = 3;

  // Segment byte is {dp,g,f,e,d,c,b,a}, active-low.
  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [0:15][6:0] GLYPH_TABLE = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Frame snapshot: the value and decimal points shown for one full frame.
  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp;
  } snap_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment glyph (bit order g..a).
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit common-anode seven-segment scan engine with per-frame snapshot.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV    = 50000,
  parameter int DIGITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      value,
  input  logic [7:0]       dp_mask,
  output logic [NUM_W-1:0] num,
  output logic [7:0]       seg,
  output logic             frame_start
);

  localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
  localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(DIGITS - 1);

  logic [PW-1:0]    presc;
  snap_t            snap;
  logic             tick;
  logic             wrap;
  logic [NUM_W-1:0] next_num;
  snap_t            src;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic [6:0]       glyph_shown;
  logic             dp_bit;

  assign tick     = en && (presc == PRE_LAST);
  assign wrap     = tick && (num == NUM_LAST);
  assign next_num = num + 1'b1;

  // On the wrap tick digit 0 must already show the new frame, so the glyph
  // is built from the live inputs rather than the stale snapshot.
  assign src    = wrap ? snap_t'({value, dp_mask}) : snap;
  assign nibble = src.value[{next_num, 2'b00} +: 4];
  assign dp_bit = ~src.dp[next_num];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .glyph  (glyph)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic lead_zero;

  // Blank when this nibble and every higher one are zero; digit 0 always shows.
  assign lead_zero   = (next_num != '0) &&
                       ((src.value >> {next_num, 2'b00}) == 32'd0);
  assign glyph_shown = lead_zero ? GLYPH_BLANK : glyph;
`else
  assign glyph_shown = glyph;
`endif

  // NOTE: all state, including the snapshot registers, is reset synchronously
  // with non-blocking assignments so every register updates on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      num         <= NUM_LAST;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
      snap        <= '0;
    end else if (!en) begin
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        presc <= '0;
        num   <= next_num;
        seg   <= {dp_bit, glyph_shown};
        if (wrap) begin
          snap <= src;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: DIV=4 and DIV=1 instances share inputs;
// expected output changes are queued with their cycle and popped by a monitor.
module tb_seg_scan_driver;

  typedef struct {
    int          cyc;
    logic [11:0] out;  // {num, seg, frame_start}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [31:0] value = '0;
  logic [7:0]  dp_mask = '0;

  logic [2:0]  num_a, num_b;
  logic [7:0]  seg_a, seg_b;
  logic        fs_a, fs_b;

  logic        sel = 1'b0;
  logic        mon_on = 1'b0;
  logic [2:0]  s_num;
  logic [7:0]  s_seg;
  logic        s_fs;

  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_scan_driver #(.DIV(4), .DIGITS(8)) u_div4 (
    .clk(clk), .rst(rst), .en(en), .value(value), .dp_mask(dp_mask),
    .num(num_a), .seg(seg_a), .frame_start(fs_a)
  );

  seg_scan_driver #(.DIV(1), .DIGITS(8)) u_div1 (
    .clk(clk), .rst(rst), .en(en), .value(value), .dp_mask(dp_mask),
    .num(num_b), .seg(seg_b), .frame_start(fs_b)
  );

  assign s_num = sel ? num_b : num_a;
  assign s_seg = sel ? seg_b : seg_a;
  assign s_fs  = sel ? fs_b  : fs_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int rel, input logic [2:0] n, input logic [7:0] s, input logic f);
    exp_t e;
    e.cyc = base + rel;
    e.out = {n, s, f};
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic use_div1, input logic [31:0] v, input logic [7:0] dp);
    @(posedge clk);
    #1;
    mon_on  = 1'b0;
    sel     = use_div1;
    rst     = 1'b1;
    en      = 1'b1;
    value   = v;
    dp_mask = dp;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
    check("reset_num", 32'(s_num), 32'd7);
    check("reset_seg", 32'(s_seg), 32'hFF);
    check("reset_frame_start", 32'(s_fs), 32'd0);
    @(negedge clk);
    #1;
    mon_on = 1'b1;
  endtask

  // Monitor: any change of {num, seg, frame_start} is one DUT event.
  logic [11:0] prev = '0;
  always @(negedge clk) begin
    logic [11:0] cur;
    exp_t        e;
    cur = {s_num, s_seg, s_fs};
    if (mon_on && (cur !== prev)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event at cycle %0d: got %h expected none", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("event_out", 32'(cur), 32'(e.out));
      end
    end
    prev = cur;
  end

  initial begin
    logic [7:0] seg_7654 [8];
    logic [7:0] seg_blank;
    seg_7654 = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    seg_blank = 8'hFF;
`else
    seg_blank = 8'hC0;
`endif

    // DIV=4, value 0123_4567: digit k shows nibble k, one slot per 4 cycles.
    do_reset(1'b0, 32'h0123_4567, 8'h00);
    push(4, 3'd0, 8'hF8, 1'b1);
    push(5, 3'd0, 8'hF8, 1'b0);
    for (int k = 1; k < 8; k++) push(4 + 4 * k, 3'(k), seg_7654[k], 1'b0);
    push(36, 3'd0, 8'hF8, 1'b1);
    push(37, 3'd0, 8'hF8, 1'b0);
    push(40, 3'd1, 8'h82, 1'b0);
    push(44, 3'd2, 8'h92, 1'b0);
    wait_to(44);

    // Mid-frame reset, then value switch at num=3 and dp on digit 2.
    do_reset(1'b0, 32'h1111_1111, 8'b0000_0100);
    push(4, 3'd0, 8'hF9, 1'b1);
    push(5, 3'd0, 8'hF9, 1'b0);
    push(8, 3'd1, 8'hF9, 1'b0);
    push(12, 3'd2, 8'h79, 1'b0);
    push(16, 3'd3, 8'hF9, 1'b0);
    for (int k = 4; k < 8; k++) push(4 + 4 * k, 3'(k), 8'hF9, 1'b0);
    push(36, 3'd0, 8'hA4, 1'b1);
    push(37, 3'd0, 8'hA4, 1'b0);
    push(40, 3'd1, 8'hA4, 1'b0);
    push(44, 3'd2, 8'h24, 1'b0);
    push(48, 3'd3, 8'hA4, 1'b0);
    // en low for 10 edges with two prescaler counts already spent.
    push(51, 3'd3, 8'hFF, 1'b0);
    push(62, 3'd4, 8'hA4, 1'b0);
    wait_to(17);
    value = 32'h2222_2222;
    wait_to(50);
    en = 1'b0;
    wait_to(60);
    en = 1'b1;
    wait_to(62);

    // DIV=1: a new digit every cycle, frame_start every 8 cycles.
    do_reset(1'b1, 32'h0123_4567, 8'h00);
    push(1, 3'd0, 8'hF8, 1'b1);
    for (int k = 1; k < 8; k++) push(1 + k, 3'(k), seg_7654[k], 1'b0);
    push(9, 3'd0, 8'hF8, 1'b1);
    push(10, 3'd1, 8'h82, 1'b0);
    wait_to(10);

    // Leading zeros: 0000_00A0.
    do_reset(1'b1, 32'h0000_00A0, 8'h00);
    push(1, 3'd0, 8'hC0, 1'b1);
    push(2, 3'd1, 8'h88, 1'b0);
    for (int k = 2; k < 8; k++) push(1 + k, 3'(k), seg_blank, 1'b0);
    push(9, 3'd0, 8'hC0, 1'b1);
    push(10, 3'd1, 8'h88, 1'b0);
    wait_to(10);
    @(negedge clk);
    #1;
    mon_on = 1'b0;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scan engine for the 8-digit, common-anode seven-segment display.
- Generates the rotating 3-bit digit index `num` that feeds the digit-select 3-8 decoder. Also generates the matching active-low segment pattern for the selected digit.
- Takes a 32-bit value (8 hex nibbles) plus a decimal-point mask from the CPU debug/IO path. Snapshots them once per frame so that no digit shows a torn value.

Parameters:
- DIV, 50000, clock cycles per digit slot (must be >= 1). At 50 MHz this gives 1 ms/digit and an 8 ms frame.
- DIGITS, 8, number of digits scanned. Fixed at 8 to match the 3-bit index; any other value is illegal.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  scan enable; 0 blanks the display and freezes scanning
- value  input  32  display value; nibble k (bits 4k+3:4k) shown on digit k
- dp_mask  input  8  bit k = 1 lights the decimal point of digit k
- num  output  3  current digit index, to the 3-8 decoder
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}; 0 = lit
- frame_start  output  1  one-cycle pulse on the cycle num becomes 0

Behaviour:
- One clock; reset is synchronous and active-high (`clk`, `rst`).
- Reset values:
  - prescaler = 0
  - num = 3'd7
  - seg = 8'hFF (all off)
  - frame_start = 0
  - snapshot value/dp registers = 0
- Prescaler:
  - Counts 0..DIV-1 while en = 1. `tick` is asserted on the cycle the count equals DIV-1, and the count wraps to 0 on that cycle.
  - Width is max(1, $clog2(DIV)).
  - With DIV = 1, tick is asserted every enabled cycle.
- On tick, num <= num+1 (mod 8), with 7 wrapping to 0.
- Frame snapshot: on the tick where num goes 7 -> 0, capture snap_value <= value and snap_dp <= dp_mask, and pulse frame_start = 1 for exactly that registered cycle.
  - Because num resets to 7, the first tick after reset loads digit 0 with a fresh snapshot.
- Segments:
  - On each tick, seg is registered with the glyph for the new num.
  - Source for the glyph: nibble num of the snapshot. On the wrap tick the glyph is built from the incoming value/dp_mask directly, so digit 0 already shows the new frame.
  - num and seg always change on the same edge; zero skew between them.
- Glyph map (active-low, bit order g..a):
  - 0 = 7'b1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - dp bit = ~dp_mask[num].
- en = 0:
  - Next cycle seg = 8'hFF and frame_start = 0.
  - Prescaler, num and snapshot hold their values.
  - On re-enable, the prescaler resumes from its held count. seg stays FF until the next tick.
- Reset asserted mid-frame: all state returns to the reset values on the next edge, and any partial frame is discarded.
- value changing mid-frame: has no effect until the next 7 -> 0 wrap.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- When defined: when a digit's nibble is 0 and all higher-index nibbles of the same snapshot are 0, its g..a bits are driven 7'h7F (off).
  - Digit 0 is never blanked, so the value 0 shows a single "0".
  - The dp bit is unaffected by blanking.
- When not defined: every digit always shows its glyph, leading zeros included.

Decomposition:
- Shared package seg_pkg holds:
  - the SEG_OFF = 8'hFF constant
  - the 16-entry active-low glyph constant table
  - the digit-index width (3)
- Natural sub-module: hex_to_seg7, combinational nibble -> 7-bit active-low glyph, instantiated once on the selected nibble.

Test Plan:
- Reset with DIV = 4, value = 32'h0123_4567, en = 1 -> num/seg follow this sequence:
  - num = 7 and seg = FF until the first tick at cycle 4.
  - Then num = 0 with seg = 7'b1111000|dp (digit 0 shows "7").
  - Then num = 1 showing "6", and so on, every 4 cycles.
  - frame_start pulses once per 32 cycles.
- value switched from 32'h1111_1111 to 32'h2222_2222 while num = 3 -> digits 4..7 still show "1"; every digit from the next num = 0 onward shows "2".
- dp_mask = 8'b0000_0100 -> seg[7] = 0 only while num = 2; seg[7] = 1 for all other digits.
- en dropped for 10 cycles mid-slot -> seg = FF on the next edge and num frozen. After en returns, the remaining prescaler count elapses before num advances.
- DIV = 1 -> num increments every cycle and frame_start pulses every 8 cycles.
- With SEG_LEADING_ZERO_BLANK_EN defined and value = 32'h0000_00A0 -> digit 1 = "A", digit 0 = "0", digits 2..7 have g..a = 7F. Without the macro, digits 2..7 show "0".
